// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared width, types and g/p formation for the 4-bit lookahead adder
package cla_pkg;

  localparam int CLA_W = 4;

  typedef logic [CLA_W-1:0] cla_nib_t;

  typedef struct packed {
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
  } cla_pg_t;

  // Per-bit generate/propagate; propagate is XOR so it doubles as the half-sum.
  function automatic cla_pg_t cla_form_pg(input cla_nib_t a, input cla_nib_t b);
    cla_pg_t pg;
    pg.g = a & b;
    pg.p = a ^ b;
    return pg;
  endfunction

endpackage

// File: rtl/cla_4_carry_unit.sv
// rtl/cla_4_carry_unit.sv - flat two-level lookahead carries; group pg/gg under CLA4_GROUP_PG_EN
module cla_4_carry_unit
  import cla_pkg::*;
(
  input  logic [3:0] i_g,
  input  logic [3:0] i_p,
  input  logic       i_cin,
  output logic [4:1] o_c
`ifdef CLA4_GROUP_PG_EN
  ,
  output logic       o_pg,
  output logic       o_gg
`endif
);

  // Each carry is a single sum-of-products from g/p/cin, never from a lower carry.
  assign o_c[1] = i_g[0]
                | (i_p[0] & i_cin);
  assign o_c[2] = i_g[1]
                | (i_p[1] & i_g[0])
                | (i_p[1] & i_p[0] & i_cin);
  assign o_c[3] = i_g[2]
                | (i_p[2] & i_g[1])
                | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_cin);
  assign o_c[4] = i_g[3]
                | (i_p[3] & i_g[2])
                | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
                | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_cin);

`ifdef CLA4_GROUP_PG_EN
  // Group terms exclude cin so an upper lookahead level can combine them.
  assign o_pg = i_p[3] & i_p[2] & i_p[1] & i_p[0];
  assign o_gg = i_g[3]
              | (i_p[3] & i_g[2])
              | (i_p[3] & i_p[2] & i_g[1])
              | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
`endif

endmodule

// File: rtl/cla_4.sv
// rtl/cla_4.sv - 4-bit carry-lookahead adder, registered outputs; optional pg/gg via CLA4_GROUP_PG_EN
module cla_4
  import cla_pkg::*;
(
  output logic [3:0] sum,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       clk,
  input  logic       rst_n
`ifdef CLA4_GROUP_PG_EN
  ,
  output logic       pg,
  output logic       gg
`endif
);

  cla_pg_t     w_pg;
  logic [4:1]  w_c;
  cla_nib_t    w_sum;
  cla_nib_t    r_sum;
  logic        r_cout;

  assign w_pg  = cla_form_pg(a, b);
  assign w_sum = w_pg.p ^ {w_c[3:1], cin};

`ifdef CLA4_GROUP_PG_EN
  logic w_grp_p;
  logic w_grp_g;
  logic r_pg;
  logic r_gg;

  cla_4_carry_unit u_carry (
    .i_g   (w_pg.g),
    .i_p   (w_pg.p),
    .i_cin (cin),
    .o_c   (w_c),
    .o_pg  (w_grp_p),
    .o_gg  (w_grp_g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pg <= 1'b0;
      r_gg <= 1'b0;
    end else begin
      r_pg <= w_grp_p;
      r_gg <= w_grp_g;
    end
  end

  assign pg = r_pg;
  assign gg = r_gg;
`else
  cla_4_carry_unit u_carry (
    .i_g   (w_pg.g),
    .i_p   (w_pg.p),
    .i_cin (cin),
    .o_c   (w_c)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_c[4];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_cla_4.sv
// tb/tb_cla_4.sv - directed and exhaustive scoreboard bench for cla_4 (pg/gg checked with CLA4_GROUP_PG_EN)
module tb_cla_4;

  logic [3:0] sum;
  logic       cout;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       clk;
  logic       rst_n;
`ifdef CLA4_GROUP_PG_EN
  logic       pg;
  logic       gg;
  localparam logic [6:0] CMP_MASK = 7'h7F;
`else
  localparam logic [6:0] CMP_MASK = 7'h1F;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] q_exp[$];

  cla_4 dut (
    .sum   (sum),
    .cout  (cout),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .clk   (clk),
    .rst_n (rst_n)
`ifdef CLA4_GROUP_PG_EN
    ,
    .pg    (pg),
    .gg    (gg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Expected {gg, pg, cout, sum} from plain integer arithmetic.
  function automatic logic [6:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    logic [4:0] s;
    logic [4:0] g;
    s = {1'b0, ma} + {1'b0, mb} + {4'b0, mc};
    g = {1'b0, ma} + {1'b0, mb};
    return {g[4], &(ma ^ mb), s};
  endfunction

  function automatic logic [6:0] observed();
`ifdef CLA4_GROUP_PG_EN
    return {gg, pg, cout, sum};
`else
    return {2'b00, cout, sum};
`endif
  endfunction

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = observed() & CMP_MASK;
    exp = exp & CMP_MASK;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] da, input logic [3:0] db, input logic dc);
    @(negedge clk);
    a   = da;
    b   = db;
    cin = dc;
    q_exp.push_back(model(da, db, dc));
  endtask

  task automatic capture(input string tag);
    logic [6:0] exp;
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s observed=empty_queue expected=pending_result", tag);
    end else begin
      exp = q_exp.pop_front();
      check(tag, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    a     = 4'hF;
    b     = 4'hF;
    cin   = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 7'h00);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", 7'h00);
    end

    @(negedge clk);
    rst_n = 1'b1;

    drive(4'hF, 4'h0, 1'b1);
    capture("full_chain");
    check("full_chain_const", 7'b01_1_0000);

    drive(4'h5, 4'h3, 1'b1);
    #2 check("mixed_before_edge", 7'b01_1_0000);
    capture("mixed");
    check("mixed_const", 7'b00_0_1001);

    drive(4'h8, 4'h8, 1'b0);
    capture("generate");
    check("generate_const", 7'b10_1_0000);

    drive(4'h7, 4'h9, 1'b0);
    capture("pre_reset");
    #2 rst_n = 1'b0;
    #1 check("midstream_reset", 7'h00);
    #1 rst_n = 1'b1;
    q_exp.push_back(model(4'h7, 4'h9, 1'b0));
    capture("after_reset_release");

    for (int i = 0; i < 512; i++) begin
      drive(i[3:0], i[7:4], i[8]);
      capture("sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
